// File: rtl/obi_wb_arbiter_pkg.sv
// rtl/obi_wb_arbiter_pkg.sv - shared types and constants for the OBI-to-Wishbone arbiter
//
// Purpose: FSM state and transaction-source enums, the read data returned on a
// timed-out cycle, and a helper that sizes the timeout counter.
package obi_wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_e;

  typedef enum logic {
    SRC_INSTR,
    SRC_DATA
  } src_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

  // Counter holds 0..limit; a disabled timeout (limit 0) still gets a 1-bit counter.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/obi_wb_arbiter_if.sv
// rtl/obi_wb_arbiter_if.sv - bundle of OBI instr/data ports, Wishbone master bus and timeout flag
//
// Purpose: groups every bus signal of obi_wb_arbiter.
// Modports:
//   master - arbiter view: takes OBI requests and Wishbone responses, drives
//            grants, responses, the Wishbone request and the timeout flag.
//   slave  - environment view (core + memory): the mirror image.
interface obi_wb_arbiter_if;

  // OBI instruction fetch port (read-only)
  logic        instr_req_i;
  logic        instr_gnt_o;
  logic [31:0] instr_addr_i;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;

  // OBI data port
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;

  // Wishbone classic master
  logic        core_cyc;
  logic        core_stb;
  logic        core_we;
  logic [3:0]  core_wstrb;
  logic [31:0] core_addr;
  logic [31:0] core_data_out;
  logic [31:0] core_data_in;
  logic        core_ack;

  // Sticky timeout flag
  logic        timeout_clr_i;
  logic        timeout_o;

  modport master (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  core_data_in, core_ack, timeout_clr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output core_cyc, core_stb, core_we, core_wstrb, core_addr, core_data_out,
    output timeout_o
  );

  modport slave (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output core_data_in, core_ack, timeout_clr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  core_cyc, core_stb, core_we, core_wstrb, core_addr, core_data_out,
    input  timeout_o
  );

endinterface

// File: rtl/obi_wb_arbiter_rr_arb2.sv
// rtl/obi_wb_arbiter_rr_arb2.sv - two-way round-robin grant with optional data priority
//
// Purpose: picks instr or data among the current requests. With PRIO_DATA set
// the data requester always wins; otherwise ties go to the source not granted
// last. The last-grant register only moves when the grant is accepted.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   req_instr, req_data  - requests
//   accept               - grant is being taken this cycle
//   gnt_instr, gnt_data  - one-hot (or zero) combinational grant
module rr_arb2
  import obi_wb_pkg::*;
#(
  parameter bit PRIO_DATA = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_instr,
  input  logic req_data,
  input  logic accept,
  output logic gnt_instr,
  output logic gnt_data
);

  src_e last;

  always_comb begin
    gnt_instr = 1'b0;
    gnt_data  = 1'b0;
    if (req_data && (PRIO_DATA || !req_instr || last == SRC_INSTR)) begin
      gnt_data = 1'b1;
    end else if (req_instr) begin
      gnt_instr = 1'b1;
    end
  end

  // Starts at instr so that the first tie after reset goes to data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= SRC_INSTR;
    end else if (accept && (gnt_instr || gnt_data)) begin
      last <= gnt_data ? SRC_DATA : SRC_INSTR;
    end
  end

endmodule

// File: rtl/obi_wb_arbiter.sv
// rtl/obi_wb_arbiter.sv - shares one Wishbone classic master between OBI instr and data ports
//
// Purpose: one transaction outstanding in total. IDLE arbitrates and grants
// combinationally, BUS runs the Wishbone cycle with latched fields until ack
// or timeout, RESP returns a one-cycle rvalid to the owning port.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   bus        - obi_wb_arbiter_if.master (OBI ports, Wishbone bus, timeout flag)
// Parameters:
//   DATA_PRIORITY  - 1: data always wins; 0: round-robin on ties
//   TIMEOUT_CYCLES - BUS cycles before forced termination; 0 disables
module obi_wb_arbiter
  import obi_wb_pkg::*;
#(
  parameter int DATA_PRIORITY  = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  obi_wb_arbiter_if.master   bus
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  // The counter reads k-1 in BUS cycle k, so the last allowed cycle sees limit-1.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e           state;
  src_e             owner;
  logic [CNT_W-1:0] cnt;

  logic        cyc_q, we_q;
  logic [3:0]  wstrb_q;
  logic [31:0] addr_q, wdata_q;
  logic        instr_rvalid_q, data_rvalid_q;
  logic [31:0] instr_rdata_q, data_rdata_q;
  logic        timeout_q;

  logic arb_instr, arb_data;
  logic gnt_instr, gnt_data;
  logic timed_out;
  logic [31:0] resp_data;

  rr_arb2 #(
    .PRIO_DATA (DATA_PRIORITY != 0)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_instr (bus.instr_req_i),
    .req_data  (bus.data_req_i),
    .accept    (state == IDLE),
    .gnt_instr (arb_instr),
    .gnt_data  (arb_data)
  );

  // Grants only in IDLE; the arbiter already requires the matching req.
  assign gnt_instr = (state == IDLE) && arb_instr;
  assign gnt_data  = (state == IDLE) && arb_data;

  // An ack on the limit cycle wins over the timeout.
  assign timed_out = (TIMEOUT_CYCLES != 0) && !bus.core_ack && (cnt == CNT_LAST);
  assign resp_data = bus.core_ack ? bus.core_data_in : TIMEOUT_RDATA;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      owner          <= SRC_INSTR;
      cnt            <= '0;
      cyc_q          <= 1'b0;
      we_q           <= 1'b0;
      wstrb_q        <= 4'h0;
      addr_q         <= 32'h0;
      wdata_q        <= 32'h0;
      instr_rvalid_q <= 1'b0;
      data_rvalid_q  <= 1'b0;
      instr_rdata_q  <= 32'h0;
      data_rdata_q   <= 32'h0;
      timeout_q      <= 1'b0;
    end else begin
      instr_rvalid_q <= 1'b0;
      data_rvalid_q  <= 1'b0;

      // Set wins over a same-cycle clear.
      if (state == BUS && timed_out) begin
        timeout_q <= 1'b1;
      end else if (bus.timeout_clr_i) begin
        timeout_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (gnt_instr || gnt_data) begin
            state   <= BUS;
            owner   <= gnt_data ? SRC_DATA : SRC_INSTR;
            cnt     <= '0;
            cyc_q   <= 1'b1;
            we_q    <= gnt_data && bus.data_we_i;
            wstrb_q <= gnt_data ? bus.data_be_i : 4'hF;
            addr_q  <= gnt_data ? bus.data_addr_i : bus.instr_addr_i;
            wdata_q <= gnt_data ? bus.data_wdata_i : 32'h0;
          end
        end
        BUS: begin
          if (bus.core_ack || timed_out) begin
            state   <= RESP;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            wstrb_q <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            if (owner == SRC_DATA) begin
              data_rvalid_q <= 1'b1;
              data_rdata_q  <= resp_data;
            end else begin
              instr_rvalid_q <= 1'b1;
              instr_rdata_q  <= resp_data;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.instr_gnt_o    = gnt_instr;
  assign bus.data_gnt_o     = gnt_data;
  assign bus.instr_rvalid_o = instr_rvalid_q;
  assign bus.instr_rdata_o  = instr_rdata_q;
  assign bus.data_rvalid_o  = data_rvalid_q;
  assign bus.data_rdata_o   = data_rdata_q;
  assign bus.core_cyc       = cyc_q;
  assign bus.core_stb       = cyc_q;
  assign bus.core_we        = we_q;
  assign bus.core_wstrb     = wstrb_q;
  assign bus.core_addr      = addr_q;
  assign bus.core_data_out  = wdata_q;
  assign bus.timeout_o      = timeout_q;

endmodule

// File: tb/tb_obi_wb_arbiter.sv
// tb/tb_obi_wb_arbiter.sv - directed self-checking bench for obi_wb_arbiter
module tb_obi_wb_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  obi_wb_arbiter_if bus_a ();
  obi_wb_arbiter_if bus_b ();

  obi_wb_arbiter #(.DATA_PRIORITY(0), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  obi_wb_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clear_inputs();
    bus_a.instr_req_i = 0; bus_a.instr_addr_i = 0; bus_a.data_req_i = 0; bus_a.data_we_i = 0;
    bus_a.data_be_i = 0; bus_a.data_addr_i = 0; bus_a.data_wdata_i = 0; bus_a.core_data_in = 0;
    bus_a.core_ack = 0; bus_a.timeout_clr_i = 0;
    bus_b.instr_req_i = 0; bus_b.instr_addr_i = 0; bus_b.data_req_i = 0; bus_b.data_we_i = 0;
    bus_b.data_be_i = 0; bus_b.data_addr_i = 0; bus_b.data_wdata_i = 0; bus_b.core_data_in = 0;
    bus_b.core_ack = 0; bus_b.timeout_clr_i = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if ({bus_a.core_cyc, bus_a.core_stb, bus_a.core_we, bus_a.core_wstrb} !== 7'h0) begin
      failures++; $display("FAIL reset_ctrl got=%h exp=0", {bus_a.core_cyc, bus_a.core_stb, bus_a.core_we, bus_a.core_wstrb});
    end
    checks++;
    if ({bus_a.core_addr, bus_a.core_data_out} !== 64'h0) begin
      failures++; $display("FAIL reset_addr_data got=%h exp=0", {bus_a.core_addr, bus_a.core_data_out});
    end
    checks++;
    if ({bus_a.instr_gnt_o, bus_a.data_gnt_o, bus_a.instr_rvalid_o, bus_a.data_rvalid_o, bus_a.timeout_o} !== 5'h0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000",
        {bus_a.instr_gnt_o, bus_a.data_gnt_o, bus_a.instr_rvalid_o, bus_a.data_rvalid_o, bus_a.timeout_o});
    end
    checks++;
    if ({bus_a.instr_rdata_o, bus_a.data_rdata_o} !== 64'h0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=0", {bus_a.instr_rdata_o, bus_a.data_rdata_o});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus_a.core_cyc !== 1'b0) begin
      failures++; $display("FAIL reset_idle_cyc got=%b exp=0", bus_a.core_cyc);
    end
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    bus_a.instr_req_i = 1; bus_a.instr_addr_i = 32'h1000; #1;
    checks++;
    if ({bus_a.instr_gnt_o, bus_a.data_gnt_o} !== 2'b10) begin
      failures++; $display("FAIL fetch_gnt got=%b exp=10", {bus_a.instr_gnt_o, bus_a.data_gnt_o});
    end
    @(negedge clk);
    bus_a.instr_req_i = 0; bus_a.core_ack = 1; bus_a.core_data_in = 32'h0000_0013; #1;
    checks++;
    if ({bus_a.core_cyc, bus_a.core_stb, bus_a.core_we, bus_a.core_wstrb, bus_a.core_addr, bus_a.core_data_out}
        !== {1'b1, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0}) begin
      failures++; $display("FAIL fetch_bus got=%h exp=%h",
        {bus_a.core_cyc, bus_a.core_stb, bus_a.core_we, bus_a.core_wstrb, bus_a.core_addr, bus_a.core_data_out},
        {1'b1, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0});
    end
    @(negedge clk);
    bus_a.core_ack = 0; bus_a.core_data_in = 32'hDEAD_BEEF; #1;
    checks++;
    if ({bus_a.instr_rvalid_o, bus_a.data_rvalid_o, bus_a.core_cyc, bus_a.instr_rdata_o} !== {3'b100, 32'h13}) begin
      failures++; $display("FAIL fetch_resp got=%h exp=%h",
        {bus_a.instr_rvalid_o, bus_a.data_rvalid_o, bus_a.core_cyc, bus_a.instr_rdata_o}, {3'b100, 32'h13});
    end
    @(negedge clk); #1;
    checks++;
    if ({bus_a.instr_rvalid_o, bus_a.instr_rdata_o} !== {1'b0, 32'h13}) begin
      failures++; $display("FAIL fetch_hold got=%h exp=%h", {bus_a.instr_rvalid_o, bus_a.instr_rdata_o}, {1'b0, 32'h13});
    end
  endtask

  task automatic test_data_write();
    @(negedge clk);
    bus_a.data_req_i = 1; bus_a.data_we_i = 1; bus_a.data_be_i = 4'b0011;
    bus_a.data_addr_i = 32'h2004; bus_a.data_wdata_i = 32'hCAFE_BABE; #1;
    checks++;
    if ({bus_a.instr_gnt_o, bus_a.data_gnt_o} !== 2'b01) begin
      failures++; $display("FAIL write_gnt got=%b exp=01", {bus_a.instr_gnt_o, bus_a.data_gnt_o});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_a.data_req_i = 0; bus_a.data_be_i = 4'hF; bus_a.data_wdata_i = 32'h0; bus_a.data_addr_i = 32'h0;
      bus_a.core_ack = (i == 3); bus_a.core_data_in = 32'h5555_AAAA; #1;
      checks++;
      if ({bus_a.core_cyc, bus_a.core_we, bus_a.core_wstrb, bus_a.core_addr, bus_a.core_data_out}
          !== {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hCAFE_BABE}) begin
        failures++; $display("FAIL write_bus_%0d got=%h exp=%h", i,
          {bus_a.core_cyc, bus_a.core_we, bus_a.core_wstrb, bus_a.core_addr, bus_a.core_data_out},
          {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hCAFE_BABE});
      end
    end
    @(negedge clk);
    bus_a.core_ack = 0; #1;
    checks++;
    if ({bus_a.data_rvalid_o, bus_a.instr_rvalid_o, bus_a.core_cyc} !== 3'b100) begin
      failures++; $display("FAIL write_resp got=%b exp=100", {bus_a.data_rvalid_o, bus_a.instr_rvalid_o, bus_a.core_cyc});
    end
    @(negedge clk); #1;
    checks++;
    if ({bus_a.data_rvalid_o, bus_a.instr_rvalid_o} !== 2'b00) begin
      failures++; $display("FAIL write_rvalid_once got=%b exp=00", {bus_a.data_rvalid_o, bus_a.instr_rvalid_o});
    end
  endtask

  task automatic test_timeout();
    int n;
    bit done;
    n = 0; done = 0;
    @(negedge clk);
    bus_a.instr_req_i = 1; bus_a.instr_addr_i = 32'h3000; #1;
    checks++;
    if (bus_a.instr_gnt_o !== 1'b1) begin
      failures++; $display("FAIL to_gnt got=%b exp=1", bus_a.instr_gnt_o);
    end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      bus_a.instr_req_i = 0; #1;
      if (bus_a.core_cyc) n++; else done = 1;
    end
    checks++;
    if (n !== 8 || !done) begin
      failures++; $display("FAIL to_bus_cycles got=%0d exp=8", n);
    end
    checks++;
    if ({bus_a.instr_rvalid_o, bus_a.instr_rdata_o, bus_a.timeout_o} !== {1'b1, 32'h0, 1'b1}) begin
      failures++; $display("FAIL to_resp got=%h exp=%h",
        {bus_a.instr_rvalid_o, bus_a.instr_rdata_o, bus_a.timeout_o}, {1'b1, 32'h0, 1'b1});
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus_a.timeout_o !== 1'b1) begin
      failures++; $display("FAIL to_sticky got=%b exp=1", bus_a.timeout_o);
    end
    @(negedge clk);
    bus_a.timeout_clr_i = 1;
    @(negedge clk);
    bus_a.timeout_clr_i = 0; #1;
    checks++;
    if (bus_a.timeout_o !== 1'b0) begin
      failures++; $display("FAIL to_clear got=%b exp=0", bus_a.timeout_o);
    end
  endtask

  task automatic test_ack_on_limit();
    int n;
    bit done;
    n = 0; done = 0;
    @(negedge clk);
    bus_a.data_req_i = 1; bus_a.data_we_i = 0; bus_a.data_be_i = 4'hF; bus_a.data_addr_i = 32'h4000; #1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      bus_a.data_req_i = 0; bus_a.core_ack = 0; #1;
      if (bus_a.core_cyc) begin
        n++;
        if (n == 8) begin
          bus_a.core_ack = 1; bus_a.core_data_in = 32'hA5A5_5A5A;
        end
      end else begin
        done = 1;
      end
    end
    bus_a.core_ack = 0;
    checks++;
    if (n !== 8 || !done) begin
      failures++; $display("FAIL limit_bus_cycles got=%0d exp=8", n);
    end
    checks++;
    if ({bus_a.data_rvalid_o, bus_a.data_rdata_o, bus_a.timeout_o} !== {1'b1, 32'hA5A5_5A5A, 1'b0}) begin
      failures++; $display("FAIL limit_resp got=%h exp=%h",
        {bus_a.data_rvalid_o, bus_a.data_rdata_o, bus_a.timeout_o}, {1'b1, 32'hA5A5_5A5A, 1'b0});
    end
  endtask

  task automatic test_round_robin();
    int ng;
    int both;
    logic [3:0] order;
    ng = 0; both = 0; order = 4'h0;
    do_reset();
    bus_a.instr_addr_i = 32'h100; bus_a.data_addr_i = 32'h200; bus_a.data_we_i = 0; bus_a.data_be_i = 4'hF;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge clk);
      bus_a.instr_req_i = 1; bus_a.data_req_i = 1;
      bus_a.core_ack = bus_a.core_cyc; bus_a.core_data_in = i; #1;
      if (bus_a.instr_gnt_o && bus_a.data_gnt_o) both++;
      if (bus_a.instr_gnt_o || bus_a.data_gnt_o) begin
        order[ng] = bus_a.data_gnt_o;
        ng++;
      end
    end
    @(negedge clk);
    bus_a.instr_req_i = 0; bus_a.data_req_i = 0; bus_a.core_ack = bus_a.core_cyc;
    repeat (3) @(negedge clk);
    bus_a.core_ack = 0;
    checks++;
    if (ng !== 4 || both !== 0) begin
      failures++; $display("FAIL rr_grants got=%0d (double=%0d) exp=4 (double=0)", ng, both);
    end
    checks++;
    if (order !== 4'b0101) begin
      failures++; $display("FAIL rr_order got=%b exp=0101 (bit0 first, 1=data)", order);
    end
  endtask

  task automatic test_priority();
    int ng;
    int ni;
    logic [3:0] order;
    ng = 0; ni = 0; order = 4'h0;
    do_reset();
    bus_b.instr_addr_i = 32'h100; bus_b.data_addr_i = 32'h200; bus_b.data_be_i = 4'hF;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge clk);
      bus_b.instr_req_i = 1; bus_b.data_req_i = 1;
      bus_b.core_ack = bus_b.core_cyc; bus_b.core_data_in = i; #1;
      if (bus_b.instr_gnt_o) ni++;
      if (bus_b.data_gnt_o) begin
        order[ng] = 1'b1;
        ng++;
      end
    end
    @(negedge clk);
    bus_b.instr_req_i = 0; bus_b.data_req_i = 0; bus_b.core_ack = bus_b.core_cyc;
    repeat (3) @(negedge clk);
    bus_b.core_ack = 0;
    checks++;
    if (ng !== 4 || order !== 4'b1111 || ni !== 0) begin
      failures++; $display("FAIL prio_order got=%b data=%0d instr=%0d exp=1111 data=4 instr=0", order, ng, ni);
    end
  endtask

  task automatic test_reset_mid_bus();
    int stray;
    stray = 0;
    @(negedge clk);
    bus_a.instr_req_i = 1; bus_a.instr_addr_i = 32'h5000;
    @(negedge clk);
    bus_a.instr_req_i = 0;
    @(negedge clk); #1;
    checks++;
    if (bus_a.core_cyc !== 1'b1) begin
      failures++; $display("FAIL rst_mid_precyc got=%b exp=1", bus_a.core_cyc);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_a.core_cyc, bus_a.core_stb, bus_a.core_we, bus_a.core_wstrb, bus_a.core_addr, bus_a.core_data_out,
         bus_a.instr_rvalid_o, bus_a.data_rvalid_o, bus_a.data_rdata_o, bus_a.timeout_o} !== 76'h0) begin
      failures++; $display("FAIL rst_mid_async got=%h exp=0",
        {bus_a.core_cyc, bus_a.core_stb, bus_a.core_we, bus_a.core_wstrb, bus_a.core_addr, bus_a.core_data_out,
         bus_a.instr_rvalid_o, bus_a.data_rvalid_o, bus_a.data_rdata_o, bus_a.timeout_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (bus_a.core_cyc || bus_a.instr_rvalid_o || bus_a.data_rvalid_o) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++; $display("FAIL rst_mid_stray got=%0d exp=0", stray);
    end
    @(negedge clk);
    bus_a.instr_req_i = 1; #1;
    checks++;
    if (bus_a.instr_gnt_o !== 1'b1) begin
      failures++; $display("FAIL rst_mid_idle_gnt got=%b exp=1", bus_a.instr_gnt_o);
    end
    @(negedge clk);
    bus_a.instr_req_i = 0; bus_a.core_ack = 1; bus_a.core_data_in = 32'h77;
    @(negedge clk);
    bus_a.core_ack = 0;
    @(negedge clk);
  endtask

  task automatic test_stray_ack();
    int bad;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_a.core_ack = 1; bus_a.core_data_in = 32'h1234_5678; #1;
      if (bus_a.core_cyc || bus_a.instr_rvalid_o || bus_a.data_rvalid_o || bus_a.instr_gnt_o || bus_a.data_gnt_o) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL stray_idle got=%0d exp=0", bad);
    end
    @(negedge clk);
    bus_a.core_ack = 0; bus_a.data_req_i = 1; bus_a.data_we_i = 0; bus_a.data_addr_i = 32'h6000;
    @(negedge clk);
    bus_a.data_req_i = 0; bus_a.core_ack = 1; bus_a.core_data_in = 32'h0BAD_F00D;
    @(negedge clk); #1;
    checks++;
    if ({bus_a.data_rvalid_o, bus_a.data_rdata_o} !== {1'b1, 32'h0BAD_F00D}) begin
      failures++; $display("FAIL stray_txn got=%h exp=%h", {bus_a.data_rvalid_o, bus_a.data_rdata_o}, {1'b1, 32'h0BAD_F00D});
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (bus_a.core_cyc || bus_a.instr_rvalid_o || bus_a.data_rvalid_o) bad++;
    end
    bus_a.core_ack = 0;
    checks++;
    if (bad !== 0 || bus_a.data_rdata_o !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL stray_resp got=%0d rdata=%h exp=0 rdata=0badf00d", bad, bus_a.data_rdata_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_data_write();
    test_timeout();
    test_ack_on_limit();
    test_round_robin();
    test_priority();
    test_reset_mid_bus();
    test_stray_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obi_wb_arbiter.md
# obi_wb_arbiter

Shares one Wishbone-classic master bus between the instruction and data OBI ports of the cv32e40p core in `processorci_top`. It replaces the direct req/gnt-to-cyc/ack wiring with proper OBI address/response phases. Arbitration is two-way, with one transaction outstanding in total and a bus timeout. The Wishbone side connects to the Controller's `core_*` bus.

## Interface
- `DATA_PRIORITY`, 0: 1 = data port always wins ties; 0 = round-robin.
- `TIMEOUT_CYCLES`, 1024: cycles in BUS before forced termination; 0 disables the timeout.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `instr_req_i` in 1, `instr_gnt_o` out 1, `instr_addr_i` in 32, `instr_rvalid_o` out 1, `instr_rdata_o` out 32: OBI fetch port, read-only.
- `data_req_i` in 1, `data_gnt_o` out 1, `data_we_i` in 1, `data_be_i` in 4, `data_addr_i` in 32, `data_wdata_i` in 32, `data_rvalid_o` out 1, `data_rdata_o` out 32: OBI data port.
- `core_cyc` out 1, `core_stb` out 1, `core_we` out 1, `core_wstrb` out 4, `core_addr` out 32, `core_data_out` out 32: Wishbone master request.
- `core_data_in` in 32, `core_ack` in 1: Wishbone response.
- `timeout_clr_i` in 1: clears the sticky flag.
- `timeout_o` out 1: sticky flag, set on any timed-out transaction.

## Operation
- States:
  - IDLE: no transaction.
  - BUS: Wishbone cycle active.
  - RESP: one-cycle rvalid to the owning port.
- IDLE:
  - Arbitrate among asserted reqs; assert the winner's gnt combinationally in the same cycle.
  - Latch source, addr, we, be, wdata; go to BUS.
  - No req: stay in IDLE, all gnt low.
- Arbitration:
  - `DATA_PRIORITY=1`: data wins whenever `data_req_i` is high.
  - Otherwise on a tie, the source not granted last wins.
  - The last-granted pointer resets to "instr", so the first tie goes to data.
  - A single requester always wins.
- BUS:
  - `core_cyc`=`core_stb`=1 with latched fields.
  - Instr: `core_we`=0, `core_wstrb`=4'hF, `core_data_out`=0.
  - Data: `core_we`=we, `core_wstrb`=be, `core_data_out`=wdata.
  - Fields are held stable until exit.
- BUS exit on `core_ack`:
  - Register `core_data_in` into the owner's rdata (write transactions also latch it; value is don't-care to the core).
  - Drop cyc/stb the next cycle; go to RESP.
- BUS exit on timeout (`TIMEOUT_CYCLES`≠0 and cycle counter reaches `TIMEOUT_CYCLES` without ack):
  - Drop cyc/stb; rdata=32'h0; set `timeout_o`; go to RESP.
- RESP: owner's rvalid=1 for exactly one cycle; go to IDLE. No gnt is issued in RESP.
- `core_ack` outside BUS is ignored.
- Timeout flag: `timeout_clr_i` clears it. A set and a clear in the same cycle leave it set.
- Non-owner rvalid is always 0. rdata holds its last value between responses.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, counter=0, pointer=instr.
  - All outputs 0: cyc, stb, we, wstrb, addr, data_out, gnt, rvalid, rdata, `timeout_o`.
- Reset mid-BUS aborts the cycle immediately; no rvalid follows.
- Example, zero-wait memory: req/gnt at T0, cyc/stb at T1, ack at T1, rvalid+rdata at T2, next gnt possible at T3. Minimum 3 cycles per transaction.
- General: rvalid is exactly 1 cycle after the ack cycle; cyc deasserts in the same cycle as rvalid.
- Timeout counter: clears on BUS entry and increments each BUS cycle without ack.
  - Ack in the same cycle the counter hits the limit counts as a normal ack: no timeout, real data returned.
- gnt never asserts without the matching req in the same cycle.

## Structure
- Package `obi_wb_pkg`:
  - `state_e` {IDLE, BUS, RESP}.
  - `src_e` {SRC_INSTR, SRC_DATA}.
  - Constant `TIMEOUT_RDATA`=32'h0.
- Natural sub-module: `rr_arb2`, a two-input round-robin grant with priority override and last-grant register, updated only on an accepted grant.
- The counter width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1.

## Test plan
- Single fetch: instr_req, addr=0x1000, memory returns 0x00000013 with ack in its first cycle. Required: gnt at T0; cyc at T1 with addr 0x1000, wstrb F, we 0; `instr_rvalid_o` at T2 with rdata 0x00000013.
- Data write: we=1, be=4'b0011, addr=0x2004, wdata=0xCAFEBABE, ack after 3 wait cycles. Required: `core_wstrb` 0011 and data held stable throughout; `data_rvalid_o` exactly 1 cycle after ack; `instr_rvalid_o` stays 0.
- Simultaneous reqs held high for 4 transactions, `DATA_PRIORITY=0`. Required: grant order data, instr, data, instr. With `DATA_PRIORITY=1`: data ×4 while instr stalls.
- `TIMEOUT_CYCLES`=8, no ack. Required: cyc drops after 8 BUS cycles; rvalid with rdata 0; `timeout_o`=1 and sticky until `timeout_clr_i`. Also ack arriving on the 8th cycle: normal completion, `timeout_o` stays 0.
- Reset asserted in BUS cycle 2. Required: cyc/stb/all outputs 0 asynchronously; after release, IDLE and no stray rvalid.
- Stray `core_ack` pulses in IDLE and RESP. Required: no state change, no rvalid.
